// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 so an idle-high
// line does not look like a falling edge when reset is released.
module uart_rx_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_d};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start bit re-checked mid-bit, data and stop sampled every
// TICK+1 clocks, byte presented on a level valid held until i_ack.
//
// Handshake: o_valid rises when a byte lands in o_dat and stays high until a
// cycle with i_ack=1; i_ack while o_valid=0 has no effect. A byte that lands
// while o_valid=1 overwrites o_dat and sets o_overrun unless i_ack is high in
// that same cycle.
module uart_rx #(
    parameter int TICK = 21,
    parameter int HALF = TICK / 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       rx,
    output logic [7:0] o_dat,
    output logic       o_valid,
    input  logic       i_ack,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [8:0] TICK_C = 9'(TICK);
    localparam logic [8:0] HALF_C = 9'(HALF);

    logic       rx_s;
    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dat_q, dat_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    uart_rx_sync2 u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (rx),
        .o_q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 9'd1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        dat_d       = dat_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (i_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == TICK_C) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start edge is seen.
                if (cnt_q == TICK_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        dat_d   = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !i_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            dat_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_dat       = dat_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx: a bit-level line driver plus a
// byte-level expected queue compared against bytes seen on each o_valid rise.
module tb_uart_rx;

    localparam int TICK = 21;
    localparam int BIT_CYC = TICK + 1;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       rx = 1'b1;
    logic       i_ack;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    logic ack_man = 1'b0;
    logic ack_auto = 1'b0;
    logic ack_sched = 1'b0;
    logic auto_en = 1'b0;
    logic sched_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_fall = -1000;
    int t_valid = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int got_rd = 0;
    logic prev_valid = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    assign i_ack = ack_man | ack_auto | ack_sched;

    uart_rx #(.TICK(TICK)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .rx          (rx),
        .o_dat       (o_dat),
        .o_valid     (o_valid),
        .i_ack       (i_ack),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    // Clock and cycle counter.
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor at the falling edge: capture bytes, count pulses, drive acks.
    always @(negedge i_clk) begin
        if (o_valid && !prev_valid) begin
            got_q.push_back(o_dat);
            t_valid = cyc;
        end
        prev_valid = o_valid;
        if (o_frame_err) fe_cnt = fe_cnt + 1;
        if (o_overrun) ovr_cnt = ovr_cnt + 1;
        if (ack_auto) ack_auto = 1'b0;
        else if (auto_en && o_valid) ack_auto = 1'b1;
        // High across the edge that samples the stop bit of the current frame.
        ack_sched = sched_en && (cyc == t_fall + 211);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at the current falling edge; ends on a falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        t_fall = cyc;
        repeat (BIT_CYC) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge i_clk);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(negedge i_clk);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            chk(tag, got_q[got_rd], exp_q.pop_front());
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    initial begin : stim
        int fe0;
        int ovr0;
        logic [7:0] b;

        // Reset state.
        repeat (3) @(negedge i_clk);
        chk("rst_dat", o_dat, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_frame_err", o_frame_err, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_busy", o_busy, 0);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);

        // Single byte, no ack: latency from pin fall to o_valid.
        fe0 = fe_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (3) @(negedge i_clk);
        chk("a5_latency", t_valid - t_fall, 212);
        chk("a5_dat", o_dat, 8'hA5);
        chk("a5_valid", o_valid, 1);
        chk("a5_no_frame_err", fe_cnt - fe0, 0);
        drain("a5_byte");
        ack_man = 1'b1;
        @(negedge i_clk);
        ack_man = 1'b0;
        chk("a5_ack_clears", o_valid, 0);

        // Back-to-back frames with auto ack.
        auto_en = 1'b1;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (5) @(negedge i_clk);
        drain("b2b_byte");
        chk("b2b_no_overrun", ovr_cnt - ovr0, 0);

        // Randomized back-to-back bytes.
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (5) @(negedge i_clk);
        drain("rand_byte");

        // Short glitch aborts in START.
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("glitch_busy_high", o_busy, 1);
        rx = 1'b1;
        repeat (20) @(negedge i_clk);
        chk("glitch_busy_low", o_busy, 0);
        chk("glitch_valid", o_valid, 0);
        chk("glitch_frame_err", fe_cnt - fe0, 0);
        drain("glitch_none");

        // Stop bit low: one frame_err, byte dropped, next frame fine.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge i_clk);
        chk("ferr_pulses", fe_cnt - fe0, 1);
        chk("ferr_valid", o_valid, 0);
        drain("ferr_dropped");
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (5) @(negedge i_clk);
        drain("ferr_next");

        // Overrun, ack, then ack coinciding with a valid stop.
        auto_en = 1'b0;
        repeat (2) @(negedge i_clk);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        @(negedge i_clk);
        chk("ovr_dat", o_dat, 8'h34);
        chk("ovr_valid", o_valid, 1);
        chk("ovr_flag", o_overrun, 1);
        ack_man = 1'b1;
        @(negedge i_clk);
        ack_man = 1'b0;
        chk("ovr_ack_valid", o_valid, 0);
        chk("ovr_ack_flag", o_overrun, 0);
        exp_q.push_back(8'h78);
        send_frame(8'h78, 1'b1);
        sched_en = 1'b1;
        send_frame(8'h56, 1'b1);
        sched_en = 1'b0;
        @(negedge i_clk);
        chk("simul_valid", o_valid, 1);
        chk("simul_dat", o_dat, 8'h56);
        chk("simul_overrun", o_overrun, 0);
        drain("ovr_bytes");

        // Asynchronous reset during data bit 4.
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (120) @(negedge i_clk);
                chk("mid_busy", o_busy, 1);
                #2 i_reset = 1'b1;
                #1;
                chk("mid_rst_dat", o_dat, 0);
                chk("mid_rst_valid", o_valid, 0);
                chk("mid_rst_busy", o_busy, 0);
                chk("mid_rst_overrun", o_overrun, 0);
                chk("mid_rst_frame_err", o_frame_err, 0);
            end
        join
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        drain("mid_rst_none");
        auto_en = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (5) @(negedge i_clk);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
